mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Single-port controller in front of the 4-lane byte-laned instruction/data memory (lanes 0..3 = byte 0..3 of each 32-bit word). It arbitrates between the fetch stage (two consecutive instructions per request) and the LSU (RV32I loads/stores selected by func3), sequences the synchronous single-ported memory, and returns registered responses. It replaces direct dual-port access, so fetch and data traffic share one physical port.

Parameters:
ADDR_W, 14, word-address width of the memory (word index = byte addr[ADDR_W+1:2]; upper byte-address bits ignored)
MAX_LSU_STREAK, 4, consecutive LSU grants allowed while fetch is waiting before fetch is forced

Ports:
clock  input  1  system clock
reset  input  1  reset; synchronous, active-high
io_if_req_valid  input  1  fetch request
io_if_req_ready  output  1  fetch request accepted this cycle
io_if_req_addr  input  64  fetch byte address (word-aligned; bits[1:0] ignored)
io_if_resp_valid  output  1  one-cycle pulse, fetch data valid
io_if_resp_inst_0  output  32  word at addr
io_if_resp_inst_1  output  32  word at addr+4
io_lsu_req_valid  input  1  LSU request
io_lsu_req_ready  output  1  LSU request accepted this cycle
io_lsu_req_addr  input  64  data byte address
io_lsu_req_wen  input  1  1 = store, 0 = load
io_lsu_req_wdata  input  32  store data (low-order bytes significant)
io_lsu_req_func3  input  3  RV32I width/sign code
io_lsu_resp_valid  output  1  one-cycle pulse, load/store complete
io_lsu_resp_data  output  32  extended load data; 0 for stores/faults
io_lsu_resp_misaligned  output  1  access faulted, memory untouched
io_mem_en  output  1  memory access enable
io_mem_addr  output  ADDR_W  word index
io_mem_wstrb  output  4  byte-lane write strobes (0 = read)
io_mem_wdata  output  32  write data, replicated across lanes
io_mem_rdata  input  32  read data, valid the cycle after a read with io_mem_en=1

Behaviour:
- States: IDLE, F_RD0, F_RD1, F_CAP, L_RD, L_CAP, S_WR, RESP. Only IDLE accepts requests.
- Grant (IDLE): LSU if lsu_valid and not (if_valid and streak >= MAX_LSU_STREAK); else IF if if_valid. Ready is asserted only for the granted requester, in IDLE only; handshake = valid & ready. Request fields are latched on handshake.
- streak: saturating counter, +1 per LSU grant, cleared on every IF grant.
- Fetch (handshake at T): T+1 F_RD0 reads word A; T+2 F_RD1 captures inst_0 and reads A+1 (wraps mod 2^ADDR_W); T+3 F_CAP captures inst_1; T+4 RESP, if_resp_valid=1.
- Load: T+1 L_RD reads word; T+2 L_CAP selects and extends; T+3 RESP. Encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Byte selected by addr[1:0]; half selected by addr[1]. Sign-extend LB/LH, zero-extend LBU/LHU.
- Store: T+1 S_WR with wstrb set as follows. SB = 0001<<addr[1:0]. SH = 0011<<addr[1:0]. SW = 1111. wdata = byte replicated x4 for SB, half replicated x2 for SH, word for SW. T+2 RESP, resp_data=0.
- Faults: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0, any other func3 (including store 100/101). No memory access; T+1 RESP with misaligned=1, data=0.
- RESP lasts exactly one cycle, then IDLE. No request is accepted during RESP. Response outputs come from registers and hold their last value after the pulse; only resp_valid drops.
- io_mem_en=1 only in F_RD0, F_RD1, L_RD, S_WR, and is forced 0 while reset=1. io_mem_wstrb=0 outside S_WR.
- Reset: state IDLE; streak 0; both resp_valid 0; inst/data registers 0; misaligned 0; both ready 0 during reset. Reset mid-transaction abandons it with no response. A store in S_WR during the reset cycle is not written.
- Requesters must hold valid and fields until ready. Dropping valid before ready is legal and simply cancels the request.

Test Plan:
- Mem preloaded word[0x10]=0x00000013, word[0x11]=0x00100093. Fetch addr 0x40 -> ready at T; mem reads at T+1 (0x10) and T+2 (0x11); if_resp_valid only at T+4 with inst_0=0x00000013, inst_1=0x00100093.
- Word[5]=0x80FF7F01. Loads at 0x14..0x17: LB@0x17 -> 0xFFFFFF80; LBU@0x17 -> 0x00000080; LH@0x16 -> 0xFFFF80FF; LHU@0x14 -> 0x00007F01; LW@0x14 -> 0x80FF7F01. Each response arrives at T+3.
- SB 0xAB@0x21 -> wstrb 0010, wdata 0xABABABAB, resp at T+2. Then SH 0x1234@0x22 -> wstrb 1100. LW@0x20 then returns 0x1234AB00 (word initially 0).
- LW@0x13, SH@0x11, and func3=011 -> misaligned=1, data 0, resp at T+1, io_mem_en never asserted.
- Both valid continuously: grants are LSU x4 then IF, repeating. With IF idle, LSU is granted back-to-back with no forced gaps.
- Reset asserted during S_WR and during F_RD1 -> no memory write, no resp_valid, outputs at reset values next cycle. A subsequent fetch completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's request, response and memory-port signals.
//   slave  : the arbiter side (takes requests and read data, drives ready, responses and memory)
//   master : the requesters plus memory side (drives requests and read data)
// Signal groups:
//   io_if_*  : fetch request/response (two consecutive instruction words)
//   io_lsu_* : RV32I load/store request/response
//   io_mem_* : synchronous single-ported byte-laned memory
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              io_if_req_valid;
  logic              io_if_req_ready;
  logic [63:0]       io_if_req_addr;
  logic              io_if_resp_valid;
  logic [31:0]       io_if_resp_inst_0;
  logic [31:0]       io_if_resp_inst_1;

  logic              io_lsu_req_valid;
  logic              io_lsu_req_ready;
  logic [63:0]       io_lsu_req_addr;
  logic              io_lsu_req_wen;
  logic [31:0]       io_lsu_req_wdata;
  logic [2:0]        io_lsu_req_func3;
  logic              io_lsu_resp_valid;
  logic [31:0]       io_lsu_resp_data;
  logic              io_lsu_resp_misaligned;

  logic              io_mem_en;
  logic [ADDR_W-1:0] io_mem_addr;
  logic [3:0]        io_mem_wstrb;
  logic [31:0]       io_mem_wdata;
  logic [31:0]       io_mem_rdata;

  modport slave (
    input  io_if_req_valid, io_if_req_addr,
    input  io_lsu_req_valid, io_lsu_req_addr, io_lsu_req_wen, io_lsu_req_wdata, io_lsu_req_func3,
    input  io_mem_rdata,
    output io_if_req_ready, io_if_resp_valid, io_if_resp_inst_0, io_if_resp_inst_1,
    output io_lsu_req_ready, io_lsu_resp_valid, io_lsu_resp_data, io_lsu_resp_misaligned,
    output io_mem_en, io_mem_addr, io_mem_wstrb, io_mem_wdata
  );

  modport master (
    output io_if_req_valid, io_if_req_addr,
    output io_lsu_req_valid, io_lsu_req_addr, io_lsu_req_wen, io_lsu_req_wdata, io_lsu_req_func3,
    output io_mem_rdata,
    input  io_if_req_ready, io_if_resp_valid, io_if_resp_inst_0, io_if_resp_inst_1,
    input  io_lsu_req_ready, io_lsu_resp_valid, io_lsu_resp_data, io_lsu_resp_misaligned,
    input  io_mem_en, io_mem_addr, io_mem_wstrb, io_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port controller sharing one synchronous byte-laned memory between instruction fetch
// (two consecutive words per request) and the LSU (RV32I loads/stores selected by func3).
// Ports:
//   clock : system clock
//   reset : synchronous, active-high; abandons any transaction in flight without a response
//   bus   : mem_port_arbiter_if.slave -- fetch/LSU handshakes, registered responses, memory port
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned StreakW = $clog2(MAX_LSU_STREAK + 1);

  typedef enum logic [2:0] {
    StIdle, StFRd0, StFRd1, StFCap, StLRd, StLCap, StSWr, StResp
  } state_e;

  state_e             state_q;
  logic [StreakW-1:0] streak_q;
  logic [ADDR_W-1:0]  word_q;
  logic [1:0]         off_q;
  logic [2:0]         func3_q;
  logic [31:0]        wdata_q;
  logic [31:0]        inst0_q, inst1_q, lsu_data_q;
  logic               if_resp_valid_q, lsu_resp_valid_q, misaligned_q;

  logic grant_lsu, grant_if, idle_ok, if_hs, lsu_hs, lsu_fault;
  logic [31:0] load_data, rd_shift, store_wdata;
  logic [15:0] rd_half;
  logic [3:0]  store_strb;

  // Fetch is forced only while it is actually waiting and the LSU has used up its streak.
  assign grant_lsu = bus.io_lsu_req_valid &&
                     !(bus.io_if_req_valid && (streak_q >= StreakW'(MAX_LSU_STREAK)));
  assign grant_if  = bus.io_if_req_valid && !grant_lsu;
  assign idle_ok   = (state_q == StIdle) && !reset;

  assign bus.io_if_req_ready  = idle_ok && grant_if;
  assign bus.io_lsu_req_ready = idle_ok && grant_lsu;
  assign if_hs  = bus.io_if_req_valid && bus.io_if_req_ready;
  assign lsu_hs = bus.io_lsu_req_valid && bus.io_lsu_req_ready;

  // Alignment / encoding check on the live request; faults never touch memory.
  always_comb begin
    lsu_fault = 1'b1;
    unique case (bus.io_lsu_req_func3)
      3'b000: lsu_fault = 1'b0;
      3'b001: lsu_fault = bus.io_lsu_req_addr[0];
      3'b010: lsu_fault = (bus.io_lsu_req_addr[1:0] != 2'b00);
      3'b100: lsu_fault = bus.io_lsu_req_wen;
      3'b101: lsu_fault = bus.io_lsu_req_wen || bus.io_lsu_req_addr[0];
      default: lsu_fault = 1'b1;
    endcase
  end

  // Load lane select and extension from the word returned in L_CAP.
  always_comb begin
    rd_shift  = bus.io_mem_rdata >> {off_q, 3'b000};
    rd_half   = off_q[1] ? bus.io_mem_rdata[31:16] : bus.io_mem_rdata[15:0];
    load_data = bus.io_mem_rdata;
    unique case (func3_q)
      3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'h0, rd_shift[7:0]};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = bus.io_mem_rdata;
    endcase
  end

  // Store data is replicated across lanes so the strobes alone pick the target bytes.
  always_comb begin
    store_strb  = 4'b1111;
    store_wdata = wdata_q;
    unique case (func3_q)
      3'b000: begin
        store_strb  = 4'b0001 << off_q;
        store_wdata = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        store_strb  = 4'b0011 << off_q;
        store_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        store_strb  = 4'b1111;
        store_wdata = wdata_q;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      streak_q         <= '0;
      word_q           <= '0;
      off_q            <= '0;
      func3_q          <= '0;
      wdata_q          <= '0;
      inst0_q          <= '0;
      inst1_q          <= '0;
      lsu_data_q       <= '0;
      if_resp_valid_q  <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      misaligned_q     <= 1'b0;
    end else begin
      // Valid flags are set only on the edge into StResp, giving a one-cycle pulse.
      if_resp_valid_q  <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (if_hs) begin
            word_q   <= bus.io_if_req_addr[ADDR_W+1:2];
            streak_q <= '0;
            state_q  <= StFRd0;
          end else if (lsu_hs) begin
            word_q  <= bus.io_lsu_req_addr[ADDR_W+1:2];
            off_q   <= bus.io_lsu_req_addr[1:0];
            func3_q <= bus.io_lsu_req_func3;
            wdata_q <= bus.io_lsu_req_wdata;
            if (streak_q < StreakW'(MAX_LSU_STREAK)) streak_q <= streak_q + StreakW'(1);
            if (lsu_fault) begin
              lsu_data_q       <= '0;
              misaligned_q     <= 1'b1;
              lsu_resp_valid_q <= 1'b1;
              state_q          <= StResp;
            end else begin
              state_q <= bus.io_lsu_req_wen ? StSWr : StLRd;
            end
          end
        end
        StFRd0: state_q <= StFRd1;
        StFRd1: begin
          inst0_q <= bus.io_mem_rdata;
          state_q <= StFCap;
        end
        StFCap: begin
          inst1_q         <= bus.io_mem_rdata;
          if_resp_valid_q <= 1'b1;
          state_q         <= StResp;
        end
        StLRd: state_q <= StLCap;
        StLCap: begin
          lsu_data_q       <= load_data;
          misaligned_q     <= 1'b0;
          lsu_resp_valid_q <= 1'b1;
          state_q          <= StResp;
        end
        StSWr: begin
          lsu_data_q       <= '0;
          misaligned_q     <= 1'b0;
          lsu_resp_valid_q <= 1'b1;
          state_q          <= StResp;
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory enables are gated by reset so a store caught by reset is never written.
  assign bus.io_mem_en    = !reset && (state_q == StFRd0 || state_q == StFRd1 ||
                                       state_q == StLRd  || state_q == StSWr);
  assign bus.io_mem_addr  = (state_q == StFRd1) ? word_q + ADDR_W'(1) : word_q;
  assign bus.io_mem_wstrb = (!reset && state_q == StSWr) ? store_strb : 4'b0000;
  assign bus.io_mem_wdata = store_wdata;

  assign bus.io_if_resp_valid       = if_resp_valid_q;
  assign bus.io_if_resp_inst_0      = inst0_q;
  assign bus.io_if_resp_inst_1      = inst1_q;
  assign bus.io_lsu_resp_valid      = lsu_resp_valid_q;
  assign bus.io_lsu_resp_data       = lsu_data_q;
  assign bus.io_lsu_resp_misaligned = misaligned_q;

  // Upper byte-address bits and fetch byte offset are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.io_if_req_addr[63:ADDR_W+2], bus.io_if_req_addr[1:0],
                              bus.io_lsu_req_addr[63:ADDR_W+2]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural byte-laned memory.
module tb_mem_port_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [0:16383];
  logic [31:0] g_en_mask;
  logic [13:0] g_a1, g_a2;
  logic [3:0]  g_strb;
  logic [31:0] g_wdata;

  mem_port_arbiter_if #(.ADDR_W(14)) bus ();

  mem_port_arbiter #(.ADDR_W(14), .MAX_LSU_STREAK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.io_mem_en) begin
      if (bus.io_mem_wstrb != 4'b0000) begin
        for (int i = 0; i < 4; i++)
          if (bus.io_mem_wstrb[i]) mem[bus.io_mem_addr][i*8 +: 8] <= bus.io_mem_wdata[i*8 +: 8];
      end else begin
        bus.io_mem_rdata <= mem[bus.io_mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] e0,
                       input logic [31:0] e1);
    int lat;
    lat = 99;
    g_en_mask = '0;
    @(negedge clock);
    bus.io_if_req_valid = 1'b1;
    bus.io_if_req_addr  = addr;
    #1 chk({tag, "_rdy"}, bus.io_if_req_ready, 1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      bus.io_if_req_valid = 1'b0;
      if (bus.io_mem_en) begin
        g_en_mask[n] = 1'b1;
        if (n == 1) g_a1 = bus.io_mem_addr;
        if (n == 2) g_a2 = bus.io_mem_addr;
      end
      if (bus.io_if_resp_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_i0"}, bus.io_if_resp_inst_0, e0);
    chk({tag, "_i1"}, bus.io_if_resp_inst_1, e1);
  endtask

  task automatic lsu(input string tag, input logic [63:0] addr, input logic wen,
                     input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] edata,
                     input logic emis, input int elat);
    int lat;
    lat = 99;
    g_en_mask = '0;
    g_strb = '0;
    g_wdata = '0;
    @(negedge clock);
    bus.io_lsu_req_valid = 1'b1;
    bus.io_lsu_req_addr  = addr;
    bus.io_lsu_req_wen   = wen;
    bus.io_lsu_req_wdata = wd;
    bus.io_lsu_req_func3 = f3;
    #1 chk({tag, "_rdy"}, bus.io_lsu_req_ready, 1);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clock);
      bus.io_lsu_req_valid = 1'b0;
      if (bus.io_mem_en) g_en_mask[n] = 1'b1;
      if (bus.io_mem_wstrb != 4'b0000) begin
        g_strb  = bus.io_mem_wstrb;
        g_wdata = bus.io_mem_wdata;
      end
      if (bus.io_lsu_resp_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_data"}, bus.io_lsu_resp_data, edata);
    chk({tag, "_mis"}, bus.io_lsu_resp_misaligned, emis);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt, last, mingap, maxgap, nresp;
    logic [9:0] seq;
    logic both;

    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[16'h10] = 32'h00000013;
    mem[16'h11] = 32'h00100093;
    mem[16'h12] = 32'h00208113;
    mem[5]      = 32'h80FF7F01;
    bus.io_mem_rdata     = '0;
    bus.io_if_req_valid  = 1'b1;
    bus.io_if_req_addr   = 64'h40;
    bus.io_lsu_req_valid = 1'b1;
    bus.io_lsu_req_addr  = 64'h14;
    bus.io_lsu_req_wen   = 1'b0;
    bus.io_lsu_req_wdata = '0;
    bus.io_lsu_req_func3 = 3'b010;

    // Reset: requests pending but nothing accepted, memory idle.
    @(negedge clock);
    @(negedge clock);
    chk("rst_if_rdy", bus.io_if_req_ready, 0);
    chk("rst_lsu_rdy", bus.io_lsu_req_ready, 0);
    chk("rst_mem_en", bus.io_mem_en, 0);
    bus.io_if_req_valid  = 1'b0;
    bus.io_lsu_req_valid = 1'b0;
    reset = 1'b0;
    chk("rst_if_rv", bus.io_if_resp_valid, 0);
    chk("rst_lsu_rv", bus.io_lsu_resp_valid, 0);
    chk("rst_i0", bus.io_if_resp_inst_0, 0);
    chk("rst_data", bus.io_lsu_resp_data, 0);
    chk("rst_mis", bus.io_lsu_resp_misaligned, 0);

    // Fetch sequencing.
    fetch("f40", 64'h40, 32'h00000013, 32'h00100093);
    chk("f40_en_mask", g_en_mask, 32'h6);
    chk("f40_a1", g_a1, 14'h10);
    chk("f40_a2", g_a2, 14'h11);
    @(negedge clock);
    chk("f40_pulse_drop", bus.io_if_resp_valid, 0);
    chk("f40_hold_i1", bus.io_if_resp_inst_1, 32'h00100093);

    // Loads with extension.
    lsu("lb17", 64'h17, 1'b0, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 3);
    lsu("lbu17", 64'h17, 1'b0, 32'h0, 3'b100, 32'h00000080, 1'b0, 3);
    lsu("lb15", 64'h15, 1'b0, 32'h0, 3'b000, 32'h0000007F, 1'b0, 3);
    lsu("lh16", 64'h16, 1'b0, 32'h0, 3'b001, 32'hFFFF80FF, 1'b0, 3);
    lsu("lhu14", 64'h14, 1'b0, 32'h0, 3'b101, 32'h00007F01, 1'b0, 3);
    lsu("lw14", 64'h14, 1'b0, 32'h0, 3'b010, 32'h80FF7F01, 1'b0, 3);

    // Stores.
    lsu("sb21", 64'h21, 1'b1, 32'h123456AB, 3'b000, 32'h0, 1'b0, 2);
    chk("sb21_strb", g_strb, 4'b0010);
    chk("sb21_wdata", g_wdata, 32'hABABABAB);
    lsu("sh22", 64'h22, 1'b1, 32'hFFFF1234, 3'b001, 32'h0, 1'b0, 2);
    chk("sh22_strb", g_strb, 4'b1100);
    chk("sh22_wdata", g_wdata, 32'h12341234);
    lsu("lw20", 64'h20, 1'b0, 32'h0, 3'b010, 32'h1234AB00, 1'b0, 3);

    // Faults: no memory access, one-cycle response.
    lsu("lw13", 64'h13, 1'b0, 32'h0, 3'b010, 32'h0, 1'b1, 1);
    chk("lw13_noen", g_en_mask, 0);
    lsu("sh11", 64'h11, 1'b1, 32'h5555, 3'b001, 32'h0, 1'b1, 1);
    chk("sh11_noen", g_en_mask, 0);
    lsu("f3_011", 64'h20, 1'b0, 32'h0, 3'b011, 32'h0, 1'b1, 1);
    chk("f3_011_noen", g_en_mask, 0);
    lsu("sbu", 64'h20, 1'b1, 32'h77, 3'b100, 32'h0, 1'b1, 1);
    chk("sbu_noen", g_en_mask, 0);
    chk("sbu_mem", mem[8], 32'h1234AB00);
    lsu("lw14b", 64'h14, 1'b0, 32'h0, 3'b010, 32'h80FF7F01, 1'b0, 3);

    // Arbitration with both requesters always valid; fetch first clears the streak.
    fetch("f40b", 64'h40, 32'h00000013, 32'h00100093);
    @(negedge clock);
    bus.io_if_req_valid  = 1'b1;
    bus.io_if_req_addr   = 64'h40;
    bus.io_lsu_req_valid = 1'b1;
    bus.io_lsu_req_addr  = 64'h14;
    bus.io_lsu_req_wen   = 1'b0;
    bus.io_lsu_req_func3 = 3'b010;
    gcnt = 0;
    seq  = '0;
    both = 1'b0;
    for (int c = 0; c < 200 && gcnt < 10; c++) begin
      if (c != 0) @(negedge clock);
      #1;
      if (bus.io_if_req_ready && bus.io_lsu_req_ready) both = 1'b1;
      if (bus.io_if_req_ready) begin
        seq[gcnt] = 1'b1;
        gcnt++;
      end else if (bus.io_lsu_req_ready) begin
        gcnt++;
      end
    end
    @(negedge clock);
    bus.io_if_req_valid  = 1'b0;
    bus.io_lsu_req_valid = 1'b0;
    chk("arb_cnt", gcnt, 10);
    chk("arb_seq", seq, 10'b1000010000);
    chk("arb_both", both, 0);
    repeat (6) @(negedge clock);

    // LSU alone: back-to-back grants, no forced gaps.
    bus.io_lsu_req_valid = 1'b1;
    gcnt = 0;
    last = -1;
    mingap = 1000;
    maxgap = 0;
    for (int c = 0; c < 200 && gcnt < 6; c++) begin
      if (c != 0) @(negedge clock);
      #1;
      if (bus.io_lsu_req_ready) begin
        if (last >= 0) begin
          if (c - last < mingap) mingap = c - last;
          if (c - last > maxgap) maxgap = c - last;
        end
        last = c;
        gcnt++;
      end
    end
    @(negedge clock);
    bus.io_lsu_req_valid = 1'b0;
    chk("b2b_cnt", gcnt, 6);
    chk("b2b_mingap", mingap, 4);
    chk("b2b_maxgap", maxgap, 4);
    repeat (5) @(negedge clock);
    chk("b2b_data", bus.io_lsu_resp_data, 32'h80FF7F01);

    // Reset during S_WR: no write, no response.
    @(negedge clock);
    bus.io_lsu_req_valid = 1'b1;
    bus.io_lsu_req_addr  = 64'h30;
    bus.io_lsu_req_wen   = 1'b1;
    bus.io_lsu_req_wdata = 32'hDEADBEEF;
    bus.io_lsu_req_func3 = 3'b010;
    #1 chk("rsw_rdy", bus.io_lsu_req_ready, 1);
    @(negedge clock);
    bus.io_lsu_req_valid = 1'b0;
    chk("rsw_strb_pre", bus.io_mem_wstrb, 4'b1111);
    reset = 1'b1;
    #1 chk("rsw_en_gated", bus.io_mem_en, 0);
    @(negedge clock);
    chk("rsw_rv", bus.io_lsu_resp_valid, 0);
    chk("rsw_data", bus.io_lsu_resp_data, 0);
    chk("rsw_mis", bus.io_lsu_resp_misaligned, 0);
    reset = 1'b0;
    nresp = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.io_lsu_resp_valid || bus.io_if_resp_valid) nresp++;
    end
    chk("rsw_noresp", nresp, 0);
    chk("rsw_mem", mem[12], 32'h0);

    // Reset during F_RD1.
    fetch("f40c", 64'h40, 32'h00000013, 32'h00100093);
    @(negedge clock);
    bus.io_if_req_valid = 1'b1;
    bus.io_if_req_addr  = 64'h44;
    #1 chk("rf_rdy", bus.io_if_req_ready, 1);
    @(negedge clock);
    bus.io_if_req_valid = 1'b0;
    chk("rf_a0", bus.io_mem_addr, 14'h11);
    @(negedge clock);
    chk("rf_a1", bus.io_mem_addr, 14'h12);
    reset = 1'b1;
    #1 chk("rf_en_gated", bus.io_mem_en, 0);
    @(negedge clock);
    chk("rf_rv", bus.io_if_resp_valid, 0);
    chk("rf_i0", bus.io_if_resp_inst_0, 0);
    chk("rf_i1", bus.io_if_resp_inst_1, 0);
    reset = 1'b0;
    nresp = 0;
    repeat (5) begin
      @(negedge clock);
      if (bus.io_lsu_resp_valid || bus.io_if_resp_valid) nresp++;
    end
    chk("rf_noresp", nresp, 0);
    fetch("f44", 64'h44, 32'h00100093, 32'h00208113);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
